// File: rtl/cpu_package.sv
// cpu_package: shared RISC-V core types, opcodes and the ID/EX bundle
package cpu_package;
    localparam int CPU_XLEN = 32;
    typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instruction_type_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] instruction;
        instruction_type_t   itype;
        logic [CPU_XLEN-1:0] immediate;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                illegal;
    } id_bundle_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF->ID and ID->EX valid/ready handshakes with the decoded bundle
interface decode_stage_if #(parameter int XLEN = 32) ();
    import cpu_package::*;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_instruction;
    logic [XLEN-1:0]   if_pc;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_instruction;
    instruction_type_t id_type;
    logic [XLEN-1:0]   id_immediate;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              id_illegal;
    modport master (
        output if_valid, if_instruction, if_pc, id_ready,
        input  if_ready, id_valid, id_pc, id_instruction, id_type, id_immediate,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_illegal
    );
    modport slave (
        input  if_valid, if_instruction, if_pc, id_ready,
        output if_ready, id_valid, id_pc, id_instruction, id_type, id_immediate,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7, id_illegal
    );
endinterface

// File: rtl/decode_stage_immediate_decode.sv
// immediate_decode: sign-extended immediate for each RISC-V instruction format
module immediate_decode import cpu_package::*; (
    input  logic [CPU_XLEN-1:7] instruction,
    input  instruction_type_t   itype,
    output logic [CPU_XLEN-1:0] immediate
);
    always_comb
        immediate = itype == I_TYPE ? {{20{instruction[31]}}, instruction[31:20]} :
                    itype == S_TYPE ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
                    itype == B_TYPE ? {{19{instruction[31]}}, instruction[31], instruction[7],
                                       instruction[30:25], instruction[11:8], 1'b0} :
                    itype == U_TYPE ? {instruction[31:12], 12'b0} :
                    itype == J_TYPE ? {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                       instruction[20], instruction[30:21], 1'b0} :
                    '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with opcode classifier, 2-entry skid buffer and registered ID/EX bundle
module decode_stage import cpu_package::*; #(
    parameter int              XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    decode_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t            state, state_nx;
    id_bundle_t        main_q, skid_q, in_b;
    instruction_type_t in_type;
    logic [XLEN-1:0]   in_imm;
    logic              known, ready_q, valid, in_xfer, ex_xfer, load_main, load_skid, pull_skid;
    always_comb begin
        in_type = R_TYPE;
        known = 1'b1;
        case (bus.if_instruction[6:0])
            OPC_OP:                                 in_type = R_TYPE;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: in_type = I_TYPE;
            OPC_STORE:                              in_type = S_TYPE;
            OPC_BRANCH:                             in_type = B_TYPE;
            OPC_LUI, OPC_AUIPC:                     in_type = U_TYPE;
            OPC_JAL:                                in_type = J_TYPE;
            default:                                known = 1'b0;
        endcase
    end
    immediate_decode u_imm (
        .instruction(bus.if_instruction[XLEN-1:7]),
        .itype      (in_type),
        .immediate  (in_imm)
    );
    // decoded before storing so a skid entry is already final when it moves to main
    assign in_b = '{pc:          bus.if_pc,
                    instruction: bus.if_instruction,
                    itype:       in_type,
                    immediate:   in_imm,
                    rs1:         bus.if_instruction[19:15],
                    rs2:         bus.if_instruction[24:20],
                    rd:          bus.if_instruction[11:7],
                    funct3:      bus.if_instruction[14:12],
                    funct7:      bus.if_instruction[31:25],
                    illegal:     !known};
    assign valid   = state != EMPTY;
    assign in_xfer = bus.if_valid & ready_q;
    assign ex_xfer = valid & bus.id_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= state_nx != FULL;
        end
    end
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pull_skid = 1'b0;
        case (state)
            EMPTY: begin
                load_main = in_xfer;
                state_nx  = in_xfer ? ONE : EMPTY;
            end
            ONE: begin
                load_main = in_xfer & ex_xfer;
                load_skid = in_xfer & !ex_xfer;
                state_nx  = load_skid ? FULL : (ex_xfer & !in_xfer) ? EMPTY : ONE;
            end
            FULL: begin
                pull_skid = ex_xfer;
                state_nx  = ex_xfer ? ONE : FULL;
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx  = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            pull_skid = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q    <= '0;
            main_q.pc <= RESET_PC;
            skid_q    <= '0;
        end else begin
            main_q <= load_main ? in_b : pull_skid ? skid_q : main_q;
            if (load_skid) skid_q <= in_b;
        end
    end
    assign bus.if_ready       = ready_q;
    assign bus.id_valid       = valid;
    assign bus.id_pc          = valid ? main_q.pc : RESET_PC;
    assign bus.id_instruction = main_q.instruction;
    assign bus.id_type        = main_q.itype;
    assign bus.id_immediate   = main_q.immediate;
    assign bus.id_rs1         = main_q.rs1;
    assign bus.id_rs2         = main_q.rs2;
    assign bus.id_rd          = main_q.rd;
    assign bus.id_funct3      = main_q.funct3;
    assign bus.id_funct7      = main_q.funct7;
    assign bus.id_illegal     = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with directed hand-decoded vectors
module tb_decode_stage;
    import cpu_package::*;
    localparam logic [31:0] RPC = 32'h0000_0080;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    decode_stage_if #(.XLEN(32)) bus ();
    decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0]       instr;
        logic [31:0]       pc;
        instruction_type_t t;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic              ill;
    } vec_t;
    vec_t vec[8];
    vec_t q[$];
    vec_t mon_e;
    int checks = 0, errors = 0, cycle = 0, pops = 0, last_pop = -10, prev_pop = -10;
    always @(posedge clk) cycle++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // monitor: every EX transfer must match the oldest accepted word
    always @(negedge clk) begin
        if (rst_n && !flush && bus.id_valid && bus.id_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h expected no output", bus.id_pc);
            end else begin
                mon_e = q.pop_front();
                chk("out_pc", bus.id_pc, mon_e.pc);
                chk("out_instr", bus.id_instruction, mon_e.instr);
                chk("out_type", 32'(bus.id_type), 32'(mon_e.t));
                chk("out_imm", bus.id_immediate, mon_e.imm);
                chk("out_rs1", 32'(bus.id_rs1), 32'(mon_e.rs1));
                chk("out_rs2", 32'(bus.id_rs2), 32'(mon_e.rs2));
                chk("out_rd", 32'(bus.id_rd), 32'(mon_e.rd));
                chk("out_funct3", 32'(bus.id_funct3), 32'(mon_e.f3));
                chk("out_funct7", 32'(bus.id_funct7), 32'(mon_e.f7));
                chk("out_illegal", 32'(bus.id_illegal), 32'(mon_e.ill));
            end
            pops++;
            prev_pop = last_pop;
            last_pop = cycle;
        end
    end
    // call just after a rising edge; returns just after the accepting edge
    task automatic offer(input int i);
        logic acc;
        bit done;
        done = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_instruction = vec[i].instr;
        bus.if_pc = vec[i].pc;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            acc = bus.if_ready && !flush;
            if (acc) q.push_back(vec[i]);
            @(posedge clk);
            #1;
            done = acc;
        end
        bus.if_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout: got no accept expected accept of vector %0d", i);
        end
    endtask
    task automatic drain();
        for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask
    task automatic check_reset_state(input string tag);
        chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, "_if_ready"}, 32'(bus.if_ready), 32'd1);
        chk({tag, "_id_pc"}, bus.id_pc, RPC);
        chk({tag, "_id_type"}, 32'(bus.id_type), 32'(R_TYPE));
        chk({tag, "_id_instr"}, bus.id_instruction, 32'd0);
        chk({tag, "_id_imm"}, bus.id_immediate, 32'd0);
        chk({tag, "_id_rd"}, 32'(bus.id_rd), 32'd0);
        chk({tag, "_id_illegal"}, 32'(bus.id_illegal), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        vec[0] = '{32'h00500093, 32'h100, I_TYPE, 32'd5,        5'd0,  5'd5,  5'd1,  3'd0, 7'h00, 1'b0};
        vec[1] = '{32'h00112223, 32'h104, S_TYPE, 32'd4,        5'd2,  5'd1,  5'd4,  3'd2, 7'h00, 1'b0};
        vec[2] = '{32'hFE000EE3, 32'h108, B_TYPE, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd29, 3'd0, 7'h7F, 1'b0};
        vec[3] = '{32'hAAAAAAAA, 32'h10C, R_TYPE, 32'd0,        5'd21, 5'd10, 5'd21, 3'd2, 7'h55, 1'b1};
        vec[4] = '{32'h12345537, 32'h200, U_TYPE, 32'h12345000, 5'd8,  5'd3,  5'd10, 3'd5, 7'h09, 1'b0};
        vec[5] = '{32'h0080006F, 32'h204, J_TYPE, 32'd8,        5'd0,  5'd8,  5'd0,  3'd0, 7'h00, 1'b0};
        vec[6] = '{32'h002081B3, 32'h208, R_TYPE, 32'd0,        5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 1'b0};
        vec[7] = '{32'h0000007F, 32'h300, R_TYPE, 32'd0,        5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 1'b1};
        bus.if_valid = 1'b0;
        bus.if_instruction = '0;
        bus.if_pc = '0;
        bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        // addi with one-cycle latency
        @(posedge clk) #1;
        bus.id_ready = 1'b1;
        offer(0);
        @(negedge clk);
        chk("latency_id_valid", 32'(bus.id_valid), 32'd1);
        drain();
        // sw then beq back-to-back, no bubble
        @(posedge clk) #1;
        offer(1);
        offer(2);
        drain();
        chk("no_bubble", 32'(last_pop - prev_pop), 32'd1);
        // illegal words still delivered exactly once
        @(posedge clk) #1;
        offer(3);
        offer(7);
        drain();
        chk("pops_after_illegal", 32'(pops), 32'd5);
        // backpressure fills ONE then FULL, order preserved on release
        @(posedge clk) #1;
        bus.id_ready = 1'b0;
        offer(4);
        offer(5);
        @(negedge clk);
        chk("full_if_ready", 32'(bus.if_ready), 32'd0);
        chk("full_id_valid", 32'(bus.id_valid), 32'd1);
        @(posedge clk) #1;
        fork
            offer(6);
            begin
                repeat (3) @(posedge clk);
                #2 bus.id_ready = 1'b1;
            end
        join
        drain();
        chk("pops_after_backpressure", 32'(pops), 32'd8);
        // flush while FULL with simultaneous IF offer and EX ready
        @(posedge clk) #1;
        bus.id_ready = 1'b0;
        offer(0);
        offer(1);
        flush = 1'b1;
        bus.id_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_instruction = vec[2].instr;
        bus.if_pc = vec[2].pc;
        q.delete();
        @(posedge clk) #1;
        flush = 1'b0;
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("flush_id_valid", 32'(bus.id_valid), 32'd0);
        chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pops_after_flush", 32'(pops), 32'd8);
        // reset for one cycle while FULL
        @(posedge clk) #1;
        bus.id_ready = 1'b0;
        offer(4);
        offer(5);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk) #1;
        check_reset_state("midreset");
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        offer(6);
        drain();
        chk("pops_after_reset", 32'(pops), 32'd9);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
